// File: rtl/dcache_wr_serializer.sv
// dcache_wr_serializer: splits one wide dcache write word into narrow AXI W
// beats (lowest beat first), then waits for the B response and reports
// completion and error status with a one-cycle pulse.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | ready for a new write word; req_ready_o high
// ST_SEND   | presenting beats on W; shift registers advance per handshake
// ST_WAIT_B | burst complete; b_ready high until the write response arrives
module dcache_wr_serializer #(
    parameter int DATA_W = 16,
    parameter int BEAT_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [DATA_W-1:0]   req_data_i,
    input  logic [DATA_W/8-1:0] req_strb_i,
    output logic                axi_wr_valid_o,
    input  logic                axi_wr_ready_i,
    output logic [BEAT_W-1:0]   axi_wr_data_o,
    output logic [BEAT_W/8-1:0] axi_wr_strb_o,
    output logic                axi_wr_last_o,
    input  logic                axi_b_valid_i,
    output logic                axi_b_ready_o,
    input  logic [1:0]          axi_b_resp_i,
    output logic                done_valid_o,
    output logic                done_err_o
);

    localparam int NUM_BEATS = DATA_W / BEAT_W;
    localparam int STRB_W    = DATA_W / 8;
    localparam int BSTRB_W   = BEAT_W / 8;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT_B = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_valid_q, done_valid_d;
    logic                done_err_q, done_err_d;

    logic [DATA_W-1:0]   data_shift;
    logic [STRB_W-1:0]   strb_shift;
    logic                beat_last;

    // Only resp[1] distinguishes error classes that matter to the controller.
    logic                unused_resp_bit0;
    assign unused_resp_bit0 = axi_b_resp_i[0];

    // Shift right by one beat with zero fill; a single-beat word has nothing
    // left after its only beat.
    generate
        if (NUM_BEATS > 1) begin : g_multi
            assign data_shift = {{BEAT_W{1'b0}}, data_q[DATA_W-1:BEAT_W]};
            assign strb_shift = {{BSTRB_W{1'b0}}, strb_q[STRB_W-1:BSTRB_W]};
        end else begin : g_single
            assign data_shift = '0;
            assign strb_shift = '0;
        end
    endgenerate

    assign beat_last = (cnt_q == LAST_IDX);

    // Outputs are decoded from registered state only, never from W ready.
    assign req_ready_o    = (state_q == ST_IDLE);
    assign axi_wr_valid_o = (state_q == ST_SEND);
    assign axi_wr_data_o  = data_q[BEAT_W-1:0];
    assign axi_wr_strb_o  = strb_q[BSTRB_W-1:0];
    assign axi_wr_last_o  = (state_q == ST_SEND) && beat_last;
    assign axi_b_ready_o  = (state_q == ST_WAIT_B);
    assign done_valid_o   = done_valid_q;
    assign done_err_o     = done_err_q;

    // Next-state logic: accept, shift beats out on W handshakes, take B.
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        strb_d       = strb_q;
        cnt_d        = cnt_q;
        done_valid_d = 1'b0;
        done_err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    data_d  = req_data_i;
                    strb_d  = req_strb_i;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (axi_wr_ready_i) begin
                    data_d = data_shift;
                    strb_d = strb_shift;
                    if (beat_last) begin
                        // Counter stays at the last index so it never wraps.
                        state_d = ST_WAIT_B;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_WAIT_B: begin
                if (axi_b_valid_i) begin
                    done_valid_d = 1'b1;
                    done_err_d   = axi_b_resp_i[1];
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers; reset aborts any burst without a done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            strb_q       <= '0;
            cnt_q        <= '0;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            strb_q       <= strb_d;
            cnt_q        <= cnt_d;
            done_valid_q <= done_valid_d;
            done_err_q   <= done_err_d;
        end
    end

endmodule

// File: tb/tb_dcache_wr_serializer.sv
// Bench for dcache_wr_serializer: directed scenarios plus randomized requests
// against a beat-queue reference model; a second instance covers one beat.
module tb_dcache_wr_serializer;

    logic        clk;
    logic        rst_n;

    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_data;
    logic [1:0]  req_strb;
    logic        w_valid;
    logic        w_ready;
    logic [7:0]  w_data;
    logic [0:0]  w_strb;
    logic        w_last;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_resp;
    logic        done_valid;
    logic        done_err;

    logic        c_req_valid;
    logic        c_req_ready;
    logic [7:0]  c_req_data;
    logic [0:0]  c_req_strb;
    logic        c_w_valid;
    logic        c_w_ready;
    logic [7:0]  c_w_data;
    logic [0:0]  c_w_strb;
    logic        c_w_last;
    logic        c_b_valid;
    logic        c_b_ready;
    logic [1:0]  c_b_resp;
    logic        c_done_valid;
    logic        c_done_err;

    int n_checks = 0;
    int n_errors = 0;
    int done_seen = 0;
    int done_exp  = 0;

    // Expected W beats: {last, strb, data}
    logic [9:0] exp_w[$];

    dcache_wr_serializer #(.DATA_W(16), .BEAT_W(8)) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_data_i     (req_data),
        .req_strb_i     (req_strb),
        .axi_wr_valid_o (w_valid),
        .axi_wr_ready_i (w_ready),
        .axi_wr_data_o  (w_data),
        .axi_wr_strb_o  (w_strb),
        .axi_wr_last_o  (w_last),
        .axi_b_valid_i  (b_valid),
        .axi_b_ready_o  (b_ready),
        .axi_b_resp_i   (b_resp),
        .done_valid_o   (done_valid),
        .done_err_o     (done_err)
    );

    dcache_wr_serializer #(.DATA_W(8), .BEAT_W(8)) u_dut_c (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_valid_i    (c_req_valid),
        .req_ready_o    (c_req_ready),
        .req_data_i     (c_req_data),
        .req_strb_i     (c_req_strb),
        .axi_wr_valid_o (c_w_valid),
        .axi_wr_ready_i (c_w_ready),
        .axi_wr_data_o  (c_w_data),
        .axi_wr_strb_o  (c_w_strb),
        .axi_wr_last_o  (c_w_last),
        .axi_b_valid_i  (c_b_valid),
        .axi_b_ready_o  (c_b_ready),
        .axi_b_resp_i   (c_b_resp),
        .done_valid_o   (c_done_valid),
        .done_err_o     (c_done_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // W-channel and done monitor, sampled mid-cycle on the falling edge.
    logic       prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b0, prev_done = 1'b0;
    logic [9:0] prev_beat = '0;
    always @(negedge clk) begin
        logic [9:0] cur;
        cur = {w_last, w_strb, w_data};
        if (rst_n && prev_rst && prev_v && !prev_r) begin
            check("w_hold_valid", w_valid, 1);
            check("w_hold_beat", cur, prev_beat);
        end
        if (rst_n && w_valid && w_ready) begin
            check("w_beat_expected", exp_w.size() != 0, 1);
            if (exp_w.size() != 0) check("w_beat", cur, exp_w.pop_front());
        end
        if (done_valid) begin
            done_seen++;
            check("done_one_cycle", prev_done, 0);
        end
        prev_v    = w_valid;
        prev_r    = w_ready;
        prev_rst  = rst_n;
        prev_beat = cur;
        prev_done = done_valid;
    end

    // One full request: stall<0 picks random W stalls per beat.
    task automatic do_req(input logic [15:0] d, input logic [1:0] s, input int stall,
                          input int b_delay, input logic [1:0] resp, input bit early);
        int n;
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_data  = d;
        req_strb  = s;
        for (int k = 0; k < 2; k++) exp_w.push_back({(k == 1), s[k], d[k*8 +: 8]});
        tick();
        req_valid = 1'b0;
        req_data  = 16'($urandom);
        req_strb  = 2'($urandom);
        if (early) begin
            b_valid = 1'b1;
            b_resp  = resp;
        end
        check("beat_valid_after_accept", w_valid, 1);
        check("req_ready_busy", req_ready, 0);
        for (int k = 0; k < 2; k++) begin
            n = (stall >= 0) ? stall : int'($urandom_range(0, 2));
            w_ready = 1'b0;
            repeat (n) begin
                check("b_ready_in_send", b_ready, 0);
                tick();
            end
            w_ready = 1'b1;
            check("b_ready_in_send", b_ready, 0);
            tick();
        end
        w_ready = 1'($urandom_range(0, 1));
        check("b_ready_wait_b", b_ready, 1);
        check("w_valid_wait_b", w_valid, 0);
        if (!early) begin
            repeat (b_delay) begin
                check("b_ready_hold", b_ready, 1);
                check("no_early_done", done_valid, 0);
                tick();
            end
        end
        b_valid = 1'b1;
        b_resp  = resp;
        tick();
        b_valid = 1'b0;
        b_resp  = 2'($urandom);
        w_ready = 1'b0;
        done_exp++;
        check("done_valid", done_valid, 1);
        check("done_err", done_err, resp[1]);
        check("req_ready_at_done", req_ready, 1);
        check("b_ready_after_b", b_ready, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_data = '0; req_strb = '0;
        w_ready = 1'b0; b_valid = 1'b0; b_resp = '0;
        c_req_valid = 1'b0; c_req_data = '0; c_req_strb = '0;
        c_w_ready = 1'b0; c_b_valid = 1'b0; c_b_resp = '0;
        tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_w_valid", w_valid, 0);
        check("rst_w_last", w_last, 0);
        check("rst_w_data", w_data, 0);
        check("rst_w_strb", w_strb, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_err", done_err, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single write, ready always high, B one cycle after last.
        do_req(16'hBEEF, 2'b11, 0, 1, 2'b00, 1'b0);
        tick();
        check("done_pulse_end", done_valid, 0);

        // W backpressure: 3 stall cycles per beat.
        do_req(16'h1234, 2'b11, 3, 0, 2'b00, 1'b0);
        tick();

        // Error responses.
        do_req(16'h5678, 2'b01, 0, 2, 2'b10, 1'b0);
        do_req(16'h9ABC, 2'b10, 1, 0, 2'b11, 1'b0);
        do_req(16'h0F0F, 2'b00, 0, 0, 2'b01, 1'b0);

        // Early B during SEND, then back-to-back request in the done cycle.
        do_req(16'h1111, 2'b11, 2, 0, 2'b00, 1'b1);
        do_req(16'hA55A, 2'b11, 0, 0, 2'b00, 1'b0);
        tick();

        // Reset after beat 0 of 0xCAFE.
        check("req_ready_pre_rst", req_ready, 1);
        req_valid = 1'b1; req_data = 16'hCAFE; req_strb = 2'b11;
        exp_w.push_back({1'b0, 1'b1, 8'hFE});
        tick();
        req_valid = 1'b0;
        w_ready = 1'b1;
        tick();
        check("rst_mid_beat1_valid", w_valid, 1);
        check("rst_mid_beat1_data", w_data, 8'hCA);
        rst_n = 1'b0;
        b_valid = 1'b1;
        #1;
        check("abort_w_valid", w_valid, 0);
        check("abort_req_ready", req_ready, 1);
        check("abort_w_last", w_last, 0);
        check("abort_b_ready", b_ready, 0);
        check("abort_done", done_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        b_valid = 1'b0;
        w_ready = 1'b0;
        tick();
        check("abort_no_done", done_valid, 0);
        do_req(16'h00FF, 2'b11, 0, 0, 2'b00, 1'b0);
        tick();

        // Randomized requests.
        for (int i = 0; i < 40; i++) begin
            bit early;
            early = 1'($urandom_range(0, 1));
            do_req(16'($urandom), 2'($urandom), -1, int'($urandom_range(0, 3)),
                   2'($urandom), early);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();

        // Single-beat instance.
        check("c_req_ready", c_req_ready, 1);
        c_req_valid = 1'b1; c_req_data = 8'h5C; c_req_strb = 1'b1;
        tick();
        c_req_valid = 1'b0;
        c_req_data = 8'h00;
        check("c_w_valid", c_w_valid, 1);
        check("c_w_data", c_w_data, 8'h5C);
        check("c_w_strb", c_w_strb, 1);
        check("c_w_last", c_w_last, 1);
        c_w_ready = 1'b1;
        tick();
        c_w_ready = 1'b0;
        check("c_w_valid_after", c_w_valid, 0);
        check("c_b_ready", c_b_ready, 1);
        c_b_valid = 1'b1; c_b_resp = 2'b00;
        tick();
        c_b_valid = 1'b0;
        check("c_done_valid", c_done_valid, 1);
        check("c_done_err", c_done_err, 0);
        check("c_req_ready_done", c_req_ready, 1);
        tick();
        check("c_done_end", c_done_valid, 0);

        check("w_beats_left", exp_w.size(), 0);
        check("done_count", done_seen, done_exp);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
